bht_sat_ctr_table: RTL and testbench
====================================

// Module: bht_sat_ctr_table
// PURPOSE
//  Branch history table of DEPTH independent CTR_W-bit saturating counters.
//  Generalises the single 2-bit taken/not-taken FSM to an indexed table with:
//   - a registered predict port;
//   - an update port with a write-back echo (wr_en/out_data);
//   - a post-reset initialisation sweep.
//  Sits between fetch (predict) and branch resolution (update).
// PARAMETERS
//  CTR_W  2  counter width in bits; MSB=1 means predict taken; legal 1..4
//  IDX_W  4  index width; DEPTH = 1<<IDX_W entries (derived localparam)
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-low reset
//  ready         out  1      1 = table initialised; predict/update accepted
//  pred_valid    in   1      predict request this cycle
//  pred_idx      in   IDX_W  entry to predict from
//  pred_out_vld  out  1      prediction valid (1 cycle after accepted request)
//  pred_taken    out  1      MSB of counter read
//  pred_ctr      out  CTR_W  full counter value read
//  upd_valid     in   1      resolved-branch update this cycle
//  upd_idx       in   IDX_W  entry to update
//  upd_torf      in   1      1 = branch taken (increment), 0 = not taken (decrement)
//  wr_en         out  1      1-cycle pulse: an entry was written last edge
//  out_data      out  CTR_W  new value of written entry (valid with wr_en)
// BEHAVIOUR
//  Reset (reset=0, async):
//   - all outputs 0; FSM -> INIT; sweep pointer = 0.
//   - table contents are don't-care until the sweep completes.
//  FSM states:
//   - INIT: each cycle writes WNT = (1<<(CTR_W-1))-1 into entry[ptr], ptr++.
//     After the entry DEPTH-1 write -> RUN. Duration is exactly DEPTH cycles
//     after reset deasserts. ready=0; pred_valid/upd_valid ignored; wr_en stays 0.
//   - RUN: ready=1 (registered, rises the cycle RUN is entered). No exit except reset.
//  Predict (RUN, pred_valid=1):
//   - edge N samples entry[pred_idx]; at N+1: pred_out_vld=1, pred_ctr=value,
//     pred_taken=value[CTR_W-1].
//   - pred_valid=0 -> pred_out_vld=0 next cycle; pred_ctr/pred_taken hold.
//  Update (RUN, upd_valid=1), applied at the edge:
//   - torf=1: ctr = (ctr==MAX) ? MAX : ctr+1, where MAX = 2^CTR_W-1.
//   - torf=0: ctr = (ctr==0) ? 0 : ctr-1.
//   - no wrap-around ever.
//   - Next cycle: wr_en=1, out_data = new value. The pulse fires even when
//     saturated (value unchanged).
//   - Back-to-back updates to the same idx each see the previous result
//     (no lost updates).
//  Predict and update in the same cycle:
//   - different idx: independent.
//   - same idx: see CONFIGURATION.
//  Reset mid-operation:
//   - immediate output clear, return to INIT.
//   - any pending prediction or write echo is discarded.
// CONFIGURATION
//  BHT_BYPASS_EN defined:
//   - same-cycle same-idx predict+update returns the post-update value on
//     pred_ctr/pred_taken.
//  BHT_BYPASS_EN undefined:
//   - returns the pre-update value.
//   - the table still takes the update.
// TESTING  (CTR_W=2, IDX_W=4 unless noted)
//  1 Deassert reset -> ready=0 for 16 cycles, then 1; predict every idx ->
//    pred_ctr=2'b01, pred_taken=0 for all.
//  2 idx3: upd_torf=1 x3 -> out_data 10,11,11 with wr_en pulses; predict idx3 ->
//    pred_taken=1, pred_ctr=11.
//  3 idx5: upd_torf=0 x2 -> out_data 00,00 (saturates, no wrap to 11).
//  4 idx7 holds 01: pred_valid+upd_valid same cycle, torf=1 ->
//    pred_ctr=10 with BHT_BYPASS_EN, 01 without; table=10 in both builds.
//  5 Assert reset mid-RUN with wr_en pending -> outputs 0 immediately;
//    INIT re-runs; idx3 reads back 01.
//  6 upd_valid/pred_valid asserted during INIT -> no wr_en, no pred_out_vld;
//    contents after INIT all 01.

Source files
------------

// File: rtl/bht_sat_ctr_table.sv
// Branch history table: DEPTH saturating counters with a registered predict port,
// an update port with write echo, and a post-reset init sweep. Define BHT_BYPASS_EN
// to forward a same-cycle update to a same-index prediction.
module bht_sat_ctr_table #(
  parameter int unsigned CTR_W = 2,
  parameter int unsigned IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_ready,
  input  logic             i_pred_valid,
  input  logic [IDX_W-1:0] i_pred_idx,
  output logic             o_pred_out_vld,
  output logic             o_pred_taken,
  output logic [CTR_W-1:0] o_pred_ctr,
  input  logic             i_upd_valid,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_torf,
  output logic             o_wr_en,
  output logic [CTR_W-1:0] o_out_data
);

  localparam int unsigned      DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WNT  = CTR_MAX >> 1;
  localparam logic [IDX_W-1:0] PTR_LAST = {IDX_W{1'b1}};

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           r_state, w_state_d;
  logic [IDX_W-1:0] r_ptr, w_ptr_d;
  logic [CTR_W-1:0] r_table [DEPTH];

  logic             r_ready;
  logic             r_pred_vld;
  logic [CTR_W-1:0] r_pred_ctr;
  logic             r_wr_en;
  logic [CTR_W-1:0] r_out_data;

  logic             w_run, w_pred_acc, w_upd_acc, w_tbl_we;
  logic [IDX_W-1:0] w_tbl_waddr;
  logic [CTR_W-1:0] w_tbl_wdata, w_upd_old, w_upd_new, w_pred_rd;

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    case (r_state)
      StInit: begin
        w_ptr_d = r_ptr + IDX_W'(1);
        if (r_ptr == PTR_LAST) w_state_d = StRun;
      end
      StRun:   w_state_d = StRun;
      default: w_state_d = StInit;
    endcase
  end

  assign w_run      = (r_state == StRun);
  assign w_pred_acc = w_run & i_pred_valid;
  assign w_upd_acc  = w_run & i_upd_valid;

  // Saturating step; never wraps in either direction.
  assign w_upd_old = r_table[i_upd_idx];
  always_comb begin
    w_upd_new = w_upd_old;
    if (i_upd_torf) begin
      if (w_upd_old != CTR_MAX) w_upd_new = w_upd_old + CTR_W'(1);
    end else begin
      if (w_upd_old != '0) w_upd_new = w_upd_old - CTR_W'(1);
    end
  end

  // Single write port shared by the init sweep and resolved-branch updates.
  assign w_tbl_we    = !w_run || w_upd_acc;
  assign w_tbl_waddr = w_run ? i_upd_idx : r_ptr;
  assign w_tbl_wdata = w_run ? w_upd_new : CTR_WNT;

  always_ff @(posedge i_clk) begin
    if (w_tbl_we) r_table[w_tbl_waddr] <= w_tbl_wdata;
  end

  always_comb begin
    w_pred_rd = r_table[i_pred_idx];
`ifdef BHT_BYPASS_EN
    if (w_upd_acc && (i_upd_idx == i_pred_idx)) w_pred_rd = w_upd_new;
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StInit;
      r_ptr      <= '0;
      r_ready    <= 1'b0;
      r_pred_vld <= 1'b0;
      r_pred_ctr <= '0;
      r_wr_en    <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_ready    <= (w_state_d == StRun);
      r_pred_vld <= w_pred_acc;
      if (w_pred_acc) r_pred_ctr <= w_pred_rd;
      r_wr_en    <= w_upd_acc;
      if (w_upd_acc) r_out_data <= w_upd_new;
    end
  end

  assign o_ready        = r_ready;
  assign o_pred_out_vld = r_pred_vld;
  assign o_pred_ctr     = r_pred_ctr;
  assign o_pred_taken   = r_pred_ctr[CTR_W-1];
  assign o_wr_en        = r_wr_en;
  assign o_out_data     = r_out_data;

endmodule

// File: tb/tb_bht_sat_ctr_table.sv
// Self-checking bench for bht_sat_ctr_table: directed scenarios plus randomized
// traffic compared every cycle against an integer-array reference model.
module tb_bht_sat_ctr_table;

  localparam int CTR_W = 2;
  localparam int IDX_W = 4;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CMAX  = (1 << CTR_W) - 1;
  localparam int WNT   = (1 << (CTR_W - 1)) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pred_valid, upd_valid, upd_torf;
  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic             ready, pred_out_vld, pred_taken, wr_en;
  logic [CTR_W-1:0] pred_ctr, out_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state.
  int mtab [DEPTH];
  int m_cyc, m_pre, m_nv;
  int e_ready, e_pvld, e_pctr, e_wr, e_data;

  int exp_up[3] = '{2, 3, 3};
  int exp_dn[2] = '{0, 0};

  always #5 clk = ~clk;

  bht_sat_ctr_table #(.CTR_W(CTR_W), .IDX_W(IDX_W)) u_dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .o_ready       (ready),
    .i_pred_valid  (pred_valid),
    .i_pred_idx    (pred_idx),
    .o_pred_out_vld(pred_out_vld),
    .o_pred_taken  (pred_taken),
    .o_pred_ctr    (pred_ctr),
    .i_upd_valid   (upd_valid),
    .i_upd_idx     (upd_idx),
    .i_upd_torf    (upd_torf),
    .o_wr_en       (wr_en),
    .o_out_data    (out_data)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: INIT lasts DEPTH edges, then the table is all WNT and ready is high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; e_ready = 0; e_pvld = 0; e_pctr = 0; e_wr = 0; e_data = 0;
    end else if (m_cyc < DEPTH) begin
      m_cyc++;
      if (m_cyc == DEPTH) begin
        foreach (mtab[i]) mtab[i] = WNT;
        e_ready = 1;
      end
      e_pvld = 0;
      e_wr   = 0;
    end else begin
      m_pre = mtab[int'(pred_idx)];
      if (upd_valid) begin
        m_nv = mtab[int'(upd_idx)] + (upd_torf ? 1 : -1);
        if (m_nv > CMAX) m_nv = CMAX;
        if (m_nv < 0) m_nv = 0;
        mtab[int'(upd_idx)] = m_nv;
        e_wr = 1;
        e_data = m_nv;
      end else begin
        e_wr = 0;
      end
      if (pred_valid) begin
        e_pvld = 1;
`ifdef BHT_BYPASS_EN
        e_pctr = mtab[int'(pred_idx)];
`else
        e_pctr = m_pre;
`endif
      end else begin
        e_pvld = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready", int'(ready), e_ready);
      check("m_pred_vld", int'(pred_out_vld), e_pvld);
      check("m_wr_en", int'(wr_en), e_wr);
      check("m_pred_ctr", int'(pred_ctr), e_pctr);
      check("m_pred_taken", int'(pred_taken), (e_pctr >> (CTR_W - 1)) & 1);
      if (e_wr != 0) check("m_out_data", int'(out_data), e_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic predict_one(input int idx, input int exp_ctr, input string name);
    pred_valid = 1'b1;
    pred_idx   = IDX_W'(idx);
    @(negedge clk);
    pred_valid = 1'b0;
    check({name, "_vld"}, int'(pred_out_vld), 1);
    check({name, "_ctr"}, int'(pred_ctr), exp_ctr);
    check({name, "_taken"}, int'(pred_taken), (exp_ctr >> (CTR_W - 1)) & 1);
  endtask

  initial begin
    rst_n = 1'b0; pred_valid = 1'b0; upd_valid = 1'b0; upd_torf = 1'b0;
    pred_idx = '0; upd_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 0);
    check("rst_pvld", int'(pred_out_vld), 0);
    check("rst_wr", int'(wr_en), 0);
    check("rst_ctr", int'(pred_ctr), 0);
    check("rst_data", int'(out_data), 0);
    chk_en = 1'b1;

    // Release reset; requests during INIT must be ignored.
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      pred_valid = 1'b1;
      upd_valid  = 1'b1;
      pred_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
      upd_idx    = IDX_W'($urandom_range(0, DEPTH - 1));
      upd_torf   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("init_ready", int'(ready), (i == DEPTH) ? 1 : 0);
      check("init_wr", int'(wr_en), 0);
      check("init_pvld", int'(pred_out_vld), 0);
    end
    pred_valid = 1'b0;
    upd_valid  = 1'b0;

    for (int i = 0; i < DEPTH; i++) predict_one(i, 1, "init_val");

    // Increment saturates at 3.
    for (int k = 0; k < 3; k++) begin
      upd_valid = 1'b1; upd_idx = IDX_W'(3); upd_torf = 1'b1;
      @(negedge clk);
      check("up_wr", int'(wr_en), 1);
      check("up_data", int'(out_data), exp_up[k]);
    end
    upd_valid = 1'b0;
    predict_one(3, 3, "up_pred");

    // Decrement saturates at 0.
    for (int k = 0; k < 2; k++) begin
      upd_valid = 1'b1; upd_idx = IDX_W'(5); upd_torf = 1'b0;
      @(negedge clk);
      check("dn_wr", int'(wr_en), 1);
      check("dn_data", int'(out_data), exp_dn[k]);
    end
    upd_valid = 1'b0;

    // Same-cycle same-index predict and update.
    pred_valid = 1'b1; pred_idx = IDX_W'(7);
    upd_valid  = 1'b1; upd_idx  = IDX_W'(7); upd_torf = 1'b1;
    @(negedge clk);
    pred_valid = 1'b0; upd_valid = 1'b0;
    check("col_wr", int'(wr_en), 1);
    check("col_data", int'(out_data), 2);
`ifdef BHT_BYPASS_EN
    check("col_pred", int'(pred_ctr), 2);
`else
    check("col_pred", int'(pred_ctr), 1);
`endif
    predict_one(7, 2, "col_after");

    // Reset while a write echo is showing.
    upd_valid = 1'b1; upd_idx = IDX_W'(3); upd_torf = 1'b0;
    @(negedge clk);
    upd_valid = 1'b0;
    check("pre_rst_wr", int'(wr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", int'(ready), 0);
    check("mid_rst_wr", int'(wr_en), 0);
    check("mid_rst_pvld", int'(pred_out_vld), 0);
    check("mid_rst_ctr", int'(pred_ctr), 0);
    check("mid_rst_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEPTH) @(negedge clk);
    check("reinit_ready", int'(ready), 1);
    predict_one(3, 1, "reinit_idx3");

    // Randomized traffic, narrow index range to provoke collisions and saturation.
    for (int c = 0; c < 3000; c++) begin
      pred_valid = 1'($urandom_range(0, 1));
      upd_valid  = 1'($urandom_range(0, 1));
      upd_torf   = 1'($urandom_range(0, 1));
      upd_idx    = IDX_W'($urandom_range(0, (c < 1500) ? 3 : DEPTH - 1));
      pred_idx   = ($urandom_range(0, 3) == 0) ? upd_idx
                                               : IDX_W'($urandom_range(0, DEPTH - 1));
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
